// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the 8-bit ALU and its wide-operation driver.
//   OP_*     : 2-bit operation select, shared by the command channel and ALU COND
//   state_t  : driver FSM states
//   sub_borrow(): unsigned borrow of one 8-bit limb subtraction
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_OP   = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  // The ALU only reports a carry for addition, so the borrow is derived here.
  function automatic logic sub_borrow(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/alu_seq_driver_if.sv
// alu_seq_driver_if: command and response channels of the wide ALU driver.
//   cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b : wide operation request
//   rsp_valid/rsp_ready/rsp_result/rsp_carry : wide result plus carry/borrow
//   master : the sequencer side issuing commands
//   slave  : the driver side executing them
interface alu_seq_driver_if #(
  parameter int NBYTES = 2
);
  localparam int W = 8 * NBYTES;

  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_carry;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_carry
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_carry
  );
endinterface

// File: rtl/alu_seq_driver.sv
// alu_seq_driver: runs a wide (8*NBYTES-bit) add/sub/and/or on an external
// 8-bit ALU, one limb per cycle, least-significant limb first. A carry/borrow
// coming into a limb is applied with an extra +1/-1 ALU pass (FIX state).
//   clk, rst_n        : clock, synchronous active-low reset
//   bus (slave)       : command/response channels
//   alu_a/alu_b/alu_cond : registered operands/op select to the ALU
//   alu_out/alu_carry : combinational ALU result and add carry
module alu_seq_driver
  import alu_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_seq_driver_if.slave  bus,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [1:0]       alu_cond,
  input  logic [7:0]       alu_out,
  input  logic             alu_carry
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  state_t        state;
  logic [1:0]    op;
  logic [IW-1:0] idx;
  logic          pending;
  logic          c_hold;
  logic          rsp_valid;
  logic [W-1:0]  rsp_result;
  logic          rsp_carry;

  logic [7:0]    a_limb  [NBYTES];
  logic [7:0]    b_limb  [NBYTES];
  logic [7:0]    r_limb  [NBYTES];
  logic [7:0]    in_a    [NBYTES];
  logic [7:0]    in_b    [NBYTES];
  logic [7:0]    r_merge [NBYTES];
  logic [W-1:0]  r_merge_flat;

  logic          c_op;
  logic          fix_out;
  logic          go_fix;
  logic          limb_carry;
  logic [IW-1:0] idx_nxt;

  // Limb split of the command operands; r_merge is R with the limb being
  // written this cycle already replaced, so DONE can load the full result.
  for (genvar g = 0; g < NBYTES; g++) begin : g_limb
    assign in_a[g]                = bus.cmd_a[8*g +: 8];
    assign in_b[g]                = bus.cmd_b[8*g +: 8];
    assign r_merge[g]             = (idx == IW'(g)) ? alu_out : r_limb[g];
    assign r_merge_flat[8*g +: 8] = r_merge[g];
  end

  assign bus.cmd_ready  = rst_n & (state == S_IDLE);
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_result = rsp_result;
  assign bus.rsp_carry  = rsp_carry;

  // Carry/borrow produced by the plain limb operation in OP.
  always_comb begin
    c_op = 1'b0;
    case (op)
      OP_ADD:  c_op = alu_carry;
      OP_SUB:  c_op = sub_borrow(a_limb[idx], b_limb[idx]);
      default: c_op = 1'b0;
    endcase
  end

  // Carry/borrow leaving the limb after the +1/-1 correction in FIX.
  always_comb begin
    fix_out = c_hold;
    if (op == OP_SUB) begin
      fix_out = c_hold | (r_limb[idx] == 8'h00);
    end else begin
      fix_out = c_hold | alu_carry;
    end
  end

  // Step control: FIX only for arithmetic ops with a carry pending into the limb.
  always_comb begin
    go_fix     = (state == S_OP) && pending && (op[1] == 1'b0);
    limb_carry = (state == S_FIX) ? fix_out : c_op;
    idx_nxt    = idx + IW'(1);
  end

  // Main FSM; ALU drive and response outputs are all registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op         <= OP_ADD;
      idx        <= '0;
      pending    <= 1'b0;
      c_hold     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_cond   <= OP_ADD;
      for (int k = 0; k < NBYTES; k++) begin
        a_limb[k] <= 8'h00;
        b_limb[k] <= 8'h00;
        r_limb[k] <= 8'h00;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op      <= bus.cmd_op;
            idx     <= '0;
            pending <= 1'b0;
            c_hold  <= 1'b0;
            for (int k = 0; k < NBYTES; k++) begin
              a_limb[k] <= in_a[k];
              b_limb[k] <= in_b[k];
            end
            alu_a    <= in_a[0];
            alu_b    <= in_b[0];
            alu_cond <= bus.cmd_op;
            state    <= S_OP;
          end
        end
        S_OP, S_FIX: begin
          r_limb[idx] <= alu_out;
          if (go_fix) begin
            // Next pass applies the incoming carry/borrow to the limb just stored.
            c_hold   <= c_op;
            alu_a    <= alu_out;
            alu_b    <= 8'h01;
            alu_cond <= op;
            state    <= S_FIX;
          end else begin
            pending <= limb_carry;
            if (idx == LAST) begin
              rsp_valid  <= 1'b1;
              rsp_result <= r_merge_flat;
              rsp_carry  <= limb_carry;
              alu_a      <= 8'h00;
              alu_b      <= 8'h00;
              alu_cond   <= OP_ADD;
              state      <= S_DONE;
            end else begin
              idx      <= idx_nxt;
              alu_a    <= a_limb[idx_nxt];
              alu_b    <= b_limb[idx_nxt];
              alu_cond <= op;
              state    <= S_OP;
            end
          end
        end
        S_DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_driver.sv
// Scoreboard bench for alu_seq_driver with NBYTES=2 and a behavioural 8-bit ALU.
module tb_alu_seq_driver;
  import alu_pkg::*;

  localparam int NBYTES = 2;
  localparam int W      = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   alu_a, alu_b, alu_out;
  logic [1:0]   alu_cond;
  logic         alu_carry;
  logic [8:0]   sum9;

  int           errors = 0;
  int           checks = 0;
  logic [W:0]   exp_q[$];
  logic [W:0]   exp_e;

  alu_seq_driver_if #(.NBYTES(NBYTES)) bus ();

  alu_seq_driver #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_cond  (alu_cond),
    .alu_out   (alu_out),
    .alu_carry (alu_carry)
  );

  always #5 clk = ~clk;

  // Reference 8-bit ALU.
  always_comb begin
    sum9      = {1'b0, alu_a} + {1'b0, alu_b};
    alu_carry = sum9[8];
    case (alu_cond)
      OP_ADD:  alu_out = sum9[7:0];
      OP_SUB:  alu_out = alu_a - alu_b;
      OP_AND:  alu_out = alu_a & alu_b;
      default: alu_out = alu_a | alu_b;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted response is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got result 0x%0h carry %0d, expected no response",
                 bus.rsp_result, bus.rsp_carry);
      end else begin
        exp_e = exp_q.pop_front();
        check("rsp_result", 32'(bus.rsp_result), 32'(exp_e[W-1:0]));
        check("rsp_carry",  32'(bus.rsp_carry),  32'(exp_e[W]));
      end
    end
  end

  // Issue one command (called at posedge+#1); returns at the negedge where rsp_valid is seen.
  task automatic send(input string name, input logic [1:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] er, input logic ec,
                      input int elat);
    int n;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_ready"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    exp_q.push_back({ec, er});
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    check({name, "_latency"}, 32'(n), 32'(elat));
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_ADD;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid",  32'(bus.rsp_valid),  32'd0);
    check("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
    check("rst_alu_a",      32'(alu_a),          32'd0);
    check("rst_cmd_ready",  32'(bus.cmd_ready),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Directed vectors: expected result, carry, latency.
    send("add_00ff", OP_ADD, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 3); @(posedge clk); #1;
    send("add_ffff", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 3); @(posedge clk); #1;
    send("add_1234", OP_ADD, 16'h1234, 16'h1111, 16'h2345, 1'b0, 2); @(posedge clk); #1;
    send("sub_0100", OP_SUB, 16'h0100, 16'h0001, 16'h00FF, 1'b0, 3); @(posedge clk); #1;
    send("sub_0000", OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 3); @(posedge clk); #1;
    send("and",      OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 2); @(posedge clk); #1;
    send("or",       OP_OR,  16'hF0F0, 16'h0F01, 16'hFFF1, 1'b0, 2); @(posedge clk); #1;

    // Backpressure in DONE with a competing command held valid.
    bus.rsp_ready = 1'b0;
    send("bp", OP_ADD, 16'h1234, 16'h1111, 16'h2345, 1'b0, 2);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_OR;
    bus.cmd_a     = 16'hAAAA;
    bus.cmd_b     = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid",  32'(bus.rsp_valid),  32'd1);
      check("bp_rsp_result", 32'(bus.rsp_result), 32'h2345);
      check("bp_rsp_carry",  32'(bus.rsp_carry),  32'd0);
      check("bp_cmd_ready",  32'(bus.cmd_ready),  32'd0);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_ready", 32'(bus.cmd_ready), 32'd1);
    check("bp_hold_result", 32'(bus.rsp_result), 32'h2345);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_no_accept", 32'(bus.rsp_valid), 32'd0);
    end

    // Reset during the FIX step of 0xFFFF+0x0001: command is abandoned.
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_ADD;
    bus.cmd_a     = 16'hFFFF;
    bus.cmd_b     = 16'h0001;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("fix_alu_a",    32'(alu_a),    32'hFF);
    check("fix_alu_b",    32'(alu_b),    32'h01);
    check("fix_alu_cond", 32'(alu_cond), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_alu_a",     32'(alu_a),         32'd0);
    check("mid_rst_alu_b",     32'(alu_b),         32'd0);
    check("mid_rst_alu_cond",  32'(alu_cond),      32'd0);
    check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    send("add_after_rst", OP_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 2);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq_driver.md
Name: alu_seq_driver

Overview:
- Command-side controller that drives the team's 8-bit combinational ALU (add/sub/and/or, with an add carry-out).
- Accepts wide (8*NBYTES-bit) operations over a valid/ready command channel.
- Issues one 8-bit ALU operation per cycle, least-significant byte first, and chains carry/borrow across bytes with a correction step.
- Returns the wide result plus carry/borrow over a valid/ready response channel.
- Sits between the datapath sequencer and the ALU instance.

Parameters:
NBYTES, 2, number of 8-bit limbs; word width W = 8*NBYTES (legal 1..8)

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  synchronous reset, active-low
CMD_VALID  input  1  command valid
CMD_READY  output  1  block can accept a command
CMD_OP  input  2  00 ADD, 01 SUB, 10 AND, 11 OR (same encoding as ALU COND)
CMD_A  input  W  operand A
CMD_B  input  W  operand B
RSP_VALID  output  1  result valid
RSP_READY  input  1  consumer accepts result
RSP_RESULT  output  W  wide result
RSP_CARRY  output  1  ADD: carry out of MSB; SUB: borrow out (1 if A<B unsigned); AND/OR: 0
ALU_A  output  8  operand to ALU
ALU_B  output  8  operand to ALU
ALU_COND  output  2  op select to ALU
ALU_OUT  input  8  ALU result (combinational from ALU_A/B/COND)
ALU_CARRY  input  1  ALU add carry (valid for A+B only)

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - State goes to IDLE.
  - RSP_VALID=0, RSP_RESULT=0, RSP_CARRY=0.
  - ALU_A=0, ALU_B=0, ALU_COND=00.
  - Internal limb index, pending flag and captured operands cleared.
  - CMD_READY=0 while RST_N=0.
  - A reset mid-operation abandons the command; no response is produced.
- FSM states: IDLE, OP, FIX, DONE.
- IDLE: CMD_READY=1. On CMD_VALID=1, capture CMD_OP/A/B, set limb i=0, clear pending, go to OP. CMD_READY=0 in all other states.
- OP (1 cycle per limb):
  - Drive ALU_A=A[i], ALU_B=B[i], ALU_COND=op.
  - At the edge, store ALU_OUT into R[i].
  - ADD: c_op = ALU_CARRY.
  - SUB: c_op = (A[i] < B[i]) unsigned, computed locally because ALU_CARRY is meaningless for subtraction.
  - AND/OR: c_op = 0.
  - If pending=1 (carry/borrow in from limb i-1) and op is ADD/SUB, go to FIX with c_op held. Otherwise pending <= c_op, then advance (below).
- FIX (1 cycle):
  - ADD: drive ALU_A=R[i], ALU_B=8'h01, ALU_COND=00. R[i] <= ALU_OUT; pending <= c_op | ALU_CARRY.
  - SUB: drive ALU_A=R[i], ALU_B=8'h01, ALU_COND=01. R[i] <= ALU_OUT; pending <= c_op | (R[i]==8'h00).
  - Then advance.
- Advance: if i==NBYTES-1, go to DONE with RSP_CARRY <= pending-out and RSP_RESULT <= R. Otherwise i <= i+1 and go to OP.
- DONE:
  - RSP_VALID=1; RSP_RESULT and RSP_CARRY held stable until RSP_READY=1.
  - On the handshake edge go to IDLE with RSP_VALID=0.
  - RSP_RESULT and RSP_CARRY retain their last value after the handshake.
  - No command is accepted in the same cycle as the response handshake; the next command is accepted one cycle later in IDLE.
- Latency from command accept to RSP_VALID: NBYTES + (number of FIX steps) cycles. Minimum NBYTES, maximum 2*NBYTES-1 (limb 0 never takes a FIX step).
- ALU_A, ALU_B and ALU_COND are registered-state-derived and glitch-free within a cycle. In IDLE and DONE they return to 0/0/00.
- At most one outstanding command; no internal queue.

Decomposition:
- Shared package alu_pkg: op encodings (OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11) and FSM state encodings. The ALU itself switches to these constants.
- No sub-module needed. The limb mux/demux is a generate loop in this module. The ALU is instantiated by the parent, not inside this block.

Test Plan (bench instantiates the ALU and wires it to the ALU_* ports; NBYTES=2):
1. ADD 0x00FF+0x0001 -> RSP_RESULT=0x0100, RSP_CARRY=0; exactly 3 compute cycles (OP0, OP1, FIX1) before RSP_VALID.
2. ADD 0xFFFF+0x0001 -> RSP_RESULT=0x0000, RSP_CARRY=1; ADD 0x1234+0x1111 -> 0x2345, carry 0, 2 compute cycles.
3. SUB 0x0100-0x0001 -> 0x00FF, carry 0; SUB 0x0000-0x0001 -> 0xFFFF, carry 1 (FIX borrow on R[1]==0x00).
4. AND 0xF0F0,0x3C3C -> 0x3030; OR 0xF0F0,0x0F01 -> 0xFFF1; carry 0; no FIX cycles.
5. Backpressure: hold RSP_READY=0 for 5 cycles in DONE -> RSP_VALID stays 1 and RSP_RESULT/RSP_CARRY are stable, CMD_READY=0; CMD_VALID asserted during this window is not accepted.
6. Assert RST_N=0 during the FIX of a 0xFFFF+0x0001 ADD -> next cycle RSP_VALID=0, ALU_*=0, CMD_READY=1 after release, no response emitted; a following ADD 0x0001+0x0001 returns 0x0002.
